// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// and a wait-state timeout so that a stalled slave cannot hang either requester.
module apb_arb_master #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                last_q, last_d;
    logic                grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                win;

    // State and output registers; reset clears everything, last grant points at port 1
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            last_q    <= 1'b1;
            grant_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
        end
    end

    // Round-robin pick: a lone request wins, a tie goes to the port not granted last
    always_comb begin
        win = (req0 && req1) ? ~last_q : req1;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        last_d    = last_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d   = win;
                    last_d    = win;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = win ? wr1 : wr0;
                    paddr_d   = win ? addr1 : addr0;
                    pwdata_d  = win ? wdata1 : wdata0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done0_d   = ~grant_q;
                    done1_d   = grant_q;
                    err_d     = pslverr;
                    rdata_d   = pwrite_q ? '0 : prdata;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done0_d   = ~grant_q;
                    done1_d   = grant_q;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign err     = err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: APB slave model plus a transaction-level reference.
module tb_apb_arb_master;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 4;

    logic          pclk = 1'b0;
    logic          presetn;
    logic [1:0]    req, wr, done;
    logic [AW-1:0] addr_a [2];
    logic [DW-1:0] wdata_a [2];
    logic [DW-1:0] rdata, pwdata, prdata;
    logic          err, psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0] paddr;

    apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req0(req[0]), .req1(req[1]), .wr0(wr[0]), .wr1(wr[1]),
        .addr0(addr_a[0]), .addr1(addr_a[1]),
        .wdata0(wdata_a[0]), .wdata1(wdata_a[1]),
        .done0(done[0]), .done1(done[1]), .rdata(rdata), .err(err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Slave: 16x8 memory, wait_n wait states per transfer, optional error
    logic [DW-1:0] mem [16];
    int            acc_cyc = 0;
    int            wait_n  = 0;
    bit            slv_err = 1'b0;

    assign pready  = psel && penable && (acc_cyc >= wait_n);
    assign pslverr = pready && slv_err;
    assign prdata  = mem[paddr];

    always @(posedge pclk) begin
        if (!presetn) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            acc_cyc <= 0;
        end else begin
            acc_cyc <= (psel && penable) ? acc_cyc + 1 : 0;
            if (psel && penable && pready && pwrite && !slv_err)
                mem[paddr] <= pwdata;
        end
    end

    // Reference state
    bit            last_m;
    logic [DW-1:0] mem_m [16];
    int            nchk = 0;
    int            nbad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        req     = '0;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        last_m  = 1'b1;
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
    endtask

    task automatic present(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p]     = 1'b1;
        wr[p]      = w;
        addr_a[p]  = a;
        wdata_a[p] = d;
    endtask

    // Follow one transfer of port p (already requesting) to its done pulse
    task automatic run_one(input int p, input bit keep, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int waits, input bit perr);
        int            acc, exp_lat, cyc;
        bit            tmo, seen, exp_err;
        logic [DW-1:0] exp_rd;
        tmo     = (waits + 1) > int'(TO);
        acc     = tmo ? int'(TO) : waits + 1;
        exp_lat = 2 + acc;
        exp_err = tmo ? 1'b1 : perr;
        exp_rd  = (tmo || w) ? '0 : mem_m[a];
        if (!tmo && w && !perr) mem_m[a] = d;
        last_m  = p[0];
        wait_n  = waits;
        slv_err = perr;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge pclk);
            cyc++;
            if (cyc == 1 && !keep) begin
                addr_a[p]  = AW'($urandom);
                wdata_a[p] = DW'($urandom);
                wr[p]      = 1'($urandom);
            end
            if (psel) begin
                check("paddr", 32'(paddr), 32'(a));
                check("pwrite", 32'(pwrite), 32'(w));
                if (w) check("pwdata", 32'(pwdata), 32'(d));
            end
            if (done != 2'b00) begin
                seen = 1'b1;
                check("done_port", 32'(done), 32'(2'b01 << p));
                check("latency", 32'(cyc), 32'(exp_lat));
                check("err", 32'(err), 32'(exp_err));
                check("rdata", 32'(rdata), 32'(exp_rd));
                check("psel_gap", 32'({psel, penable}), 32'(0));
                if (!keep) req[p] = 1'b0;
            end
        end
        check("done_seen", 32'(seen), 32'(1));
    endtask

    // Both ports request at once; reference picks the order
    task automatic pair(input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input int waits, input bit perr);
        present(0, w0, a0, d0);
        present(1, w1, a1, d1);
        if (last_m) begin
            run_one(0, 1'b0, w0, a0, d0, waits, perr);
            run_one(1, 1'b0, w1, a1, d1, waits, perr);
        end else begin
            run_one(1, 1'b0, w1, a1, d1, waits, perr);
            run_one(0, 1'b0, w0, a0, d0, waits, perr);
        end
    endtask

    initial begin
        req = '0; wr = '0;
        addr_a[0] = '0; addr_a[1] = '0; wdata_a[0] = '0; wdata_a[1] = '0;
        do_reset();
        @(negedge pclk);
        check("rst_ctrl", 32'({psel, penable, pwrite}), 32'(0));
        check("rst_bus", 32'({paddr, pwdata}), 32'(0));
        check("rst_resp", 32'({done, err, rdata}), 32'(0));

        // Port 0 write then read, zero waits
        present(0, 1'b1, 4'h3, 8'hA5);
        run_one(0, 1'b0, 1'b1, 4'h3, 8'hA5, 0, 1'b0);
        present(0, 1'b0, 4'h3, 8'h00);
        run_one(0, 1'b0, 1'b0, 4'h3, 8'h00, 0, 1'b0);

        // Continuous requests from both ports alternate
        present(0, 1'b1, 4'h1, 8'h11);
        present(1, 1'b1, 4'h2, 8'h22);
        for (int k = 0; k < 4; k++) begin
            if (last_m) run_one(0, 1'b1, 1'b1, 4'h1, 8'h11, 0, 1'b0);
            else        run_one(1, 1'b1, 1'b1, 4'h2, 8'h22, 0, 1'b0);
        end
        req = '0;

        // Slave wait states, timeout, error and pready-vs-timeout
        present(1, 1'b0, 4'h2, 8'h00);
        run_one(1, 1'b0, 1'b0, 4'h2, 8'h00, 3, 1'b0);
        present(0, 1'b0, 4'h1, 8'h00);
        run_one(0, 1'b0, 1'b0, 4'h1, 8'h00, 100, 1'b0);
        present(0, 1'b1, 4'h7, 8'h5C);
        run_one(0, 1'b1 == 1'b0, 1'b1, 4'h7, 8'h5C, 0, 1'b1);
        present(1, 1'b0, 4'h1, 8'h00);
        run_one(1, 1'b0, 1'b0, 4'h1, 8'h00, int'(TO) - 1, 1'b0);
        present(1, 1'b0, 4'h2, 8'h00);
        run_one(1, 1'b0, 1'b0, 4'h2, 8'h00, int'(TO) - 1, 1'b1);

        // Reset during ACCESS
        present(1, 1'b0, 4'h5, 8'h00);
        wait_n = 100;
        slv_err = 1'b0;
        repeat (3) @(negedge pclk);
        check("in_access", 32'({psel, penable}), 32'(2'b11));
        #2 presetn = 1'b0;
        #1;
        check("async_rst", 32'({psel, penable}), 32'(0));
        check("rst_nodone", 32'(done), 32'(0));
        @(negedge pclk);
        req = '0;
        @(negedge pclk);
        presetn = 1'b1;
        last_m  = 1'b1;
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        @(negedge pclk);
        check("post_rst", 32'({done, psel}), 32'(0));
        pair(1'b1, 4'h4, 8'h44, 1'b1, 4'h4, 8'h55, 0, 1'b0);

        // Randomized traffic against the reference
        for (int it = 0; it < 40; it++) begin
            int            mode, wt, p;
            bit            pe, w0, w1;
            logic [AW-1:0] a0, a1;
            logic [DW-1:0] d0, d1;
            mode = $urandom_range(0, 2);
            wt   = $urandom_range(0, TO + 1);
            pe   = ($urandom_range(0, 3) == 0);
            w0   = 1'($urandom); w1 = 1'($urandom);
            a0   = AW'($urandom_range(0, 3)); a1 = AW'($urandom_range(0, 3));
            d0   = DW'($urandom); d1 = DW'($urandom);
            if (mode == 2) begin
                pair(w0, a0, d0, w1, a1, d1, wt, pe);
            end else begin
                p = mode;
                present(p, w0, a0, d0);
                run_one(p, 1'b0, w0, a0, d0, wt, pe);
            end
        end

        repeat (2) @(negedge pclk);
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
